fetch_sequencer: RTL and testbench

//   Owns the fetch PC and sequences instruction fetch over a req/gnt/rvalid imem port.

---
 rtl/fetch_sequencer_if.sv | 48 ++++
 rtl/fetch_sequencer.sv | 99 +++++++++
 tb/tb_fetch_sequencer.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_if.sv
// rtl/fetch_sequencer_if.sv - imem, decode and redirect signals of the fetch sequencer
interface fetch_sequencer_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_ready;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        exc_req;
   logic [31:0] pc;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_gnt,
      input  imem_rvalid,
      input  imem_rdata,
      output inst_valid,
      output inst,
      output inst_pc,
      input  inst_ready,
      input  redirect_valid,
      input  redirect_pc,
      input  exc_req,
      output pc
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_gnt,
      output imem_rvalid,
      output imem_rdata,
      input  inst_valid,
      input  inst,
      input  inst_pc,
      output inst_ready,
      output redirect_valid,
      output redirect_pc,
      output exc_req,
      input  pc
   );
endinterface

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - fetch PC owner sequencing imem req/gnt/rvalid into a decode handshake
module fetch_sequencer #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [31:0] EXC_VECTOR   = 32'h0000_0080
) (
   input  logic               clk,
   input  logic               reset,
   fetch_sequencer_if.master  bus
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

   state_t      state;
   logic [31:0] pc_q;
   logic [31:0] inst_q;
   logic [31:0] inst_pc_q;
   logic        kill;
   logic        pend;
   logic [31:0] pend_pc;

   logic        redir;
   logic [31:0] redir_tgt;

   // Exception entry always beats a same-cycle branch.
   always_comb begin
      redir     = bus.exc_req | bus.redirect_valid;
      redir_tgt = bus.exc_req ? EXC_VECTOR : (bus.redirect_pc & 32'hFFFF_FFFC);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         pc_q      <= RESET_VECTOR;
         inst_q    <= 32'h0;
         inst_pc_q <= 32'h0;
         kill      <= 1'b0;
         pend      <= 1'b0;
         pend_pc   <= 32'h0;
      end else begin
         case (state)
            IDLE: begin
               if (redir) pc_q <= redir_tgt;
               state <= REQ;
            end
            REQ: begin
               // The address is frozen until grant; a redirect seen before then
               // is parked and applied together with killing the granted word.
               if (bus.imem_gnt) begin
                  state <= WAIT;
                  pend  <= 1'b0;
                  if (redir) begin
                     pc_q <= redir_tgt;
                     kill <= 1'b1;
                  end else if (pend) begin
                     pc_q <= pend_pc;
                     kill <= 1'b1;
                  end
               end else if (redir) begin
                  pend    <= 1'b1;
                  pend_pc <= redir_tgt;
               end
            end
            WAIT: begin
               if (redir) pc_q <= redir_tgt;
               if (bus.imem_rvalid) begin
                  if (kill || redir) begin
                     kill  <= 1'b0;
                     state <= REQ;
                  end else begin
                     inst_q    <= bus.imem_rdata;
                     inst_pc_q <= pc_q;
                     state     <= HOLD;
                  end
               end else if (redir) begin
                  kill <= 1'b1;
               end
            end
            HOLD: begin
               if (redir) begin
                  pc_q  <= redir_tgt;
                  state <= REQ;
               end else if (bus.inst_ready) begin
                  pc_q  <= pc_q + 32'd4;
                  state <= REQ;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.imem_req   = (state == REQ);
   assign bus.imem_addr  = pc_q;
   assign bus.inst_valid = (state == HOLD);
   assign bus.inst       = inst_q;
   assign bus.inst_pc    = inst_pc_q;
   assign bus.pc         = pc_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed and randomized bench for fetch_sequencer
module tb_fetch_sequencer;
   localparam logic [31:0] RST_V = 32'h0000_0000;
   localparam logic [31:0] EXC_V = 32'h0000_0080;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   fetch_sequencer_if bus ();

   fetch_sequencer #(.RESET_VECTOR(RST_V), .EXC_VECTOR(EXC_V)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_total = 0;
   int n_pass  = 0;
   int n_fail  = 0;
   int cyc     = 0;

   int gnt_mode = 1;   // 0 random, 1 always, 2 never
   int rv_mode  = 1;   // 0 memory model, 1 always, 2 never

   bit          outstanding = 0;
   int          rdelay = 0;
   logic [31:0] raddr = 32'h0;

   logic [31:0] exp_pc = RST_V;
   bit          hold_prev = 0;
   logic [31:0] prev_inst, prev_ipc;
   bit          req_prev = 0;
   logic [31:0] prev_addr;
   int          transfers = 0;

   function automatic logic [31:0] memf(input logic [31:0] a);
      return (a ^ 32'hC3A5_5A3C) + {a[15:0], a[31:16]};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: accepted words form the sequence target, target+4, ... of the latest redirect.
   task automatic model();
      if (reset) begin
         exp_pc    = RST_V;
         hold_prev = 0;
         req_prev  = 0;
      end else begin
         if (hold_prev) begin
            chk("hold_valid", 32'(bus.inst_valid), 32'd1);
            chk("hold_inst", bus.inst, prev_inst);
            chk("hold_inst_pc", bus.inst_pc, prev_ipc);
         end
         if (req_prev) begin
            chk("req_held", 32'(bus.imem_req), 32'd1);
            chk("addr_stable", bus.imem_addr, prev_addr);
         end
         if (bus.imem_req) begin
            chk("addr_align", 32'(bus.imem_addr[1:0]), 32'd0);
            chk("req_excl_valid", 32'(bus.inst_valid), 32'd0);
         end
         if (bus.inst_valid && bus.inst_ready) begin
            chk("xfer_pc", bus.inst_pc, exp_pc);
            chk("xfer_inst", bus.inst, memf(exp_pc));
            exp_pc = exp_pc + 32'd4;
            transfers++;
         end
         if (bus.exc_req) exp_pc = EXC_V;
         else if (bus.redirect_valid) exp_pc = bus.redirect_pc & 32'hFFFF_FFFC;
         hold_prev = bus.inst_valid && !bus.inst_ready && !bus.exc_req && !bus.redirect_valid;
         prev_inst = bus.inst;
         prev_ipc  = bus.inst_pc;
         req_prev  = bus.imem_req && !bus.imem_gnt;
         prev_addr = bus.imem_addr;
      end
   endtask

   task automatic cycle();
      if (reset) begin
         outstanding     = 0;
         bus.imem_gnt    = 1'b0;
         bus.imem_rvalid = 1'b0;
      end else begin
         case (rv_mode)
            0: begin
               if (outstanding && rdelay == 0) begin
                  bus.imem_rvalid = 1'b1;
                  bus.imem_rdata  = memf(raddr);
                  outstanding     = 0;
               end else begin
                  if (outstanding) rdelay--;
                  bus.imem_rvalid = 1'b0;
                  bus.imem_rdata  = $urandom;
               end
            end
            1: begin
               bus.imem_rvalid = 1'b1;
               bus.imem_rdata  = memf(bus.imem_addr);
            end
            default: begin
               bus.imem_rvalid = 1'b0;
               bus.imem_rdata  = $urandom;
            end
         endcase
         case (gnt_mode)
            0: begin
               bus.imem_gnt = bus.imem_req && !outstanding && ($urandom_range(0, 2) != 0);
               if (bus.imem_gnt) begin
                  outstanding = 1;
                  raddr       = bus.imem_addr;
                  rdelay      = $urandom_range(0, 2);
               end
            end
            1: bus.imem_gnt = 1'b1;
            default: bus.imem_gnt = 1'b0;
         endcase
      end
      model();
      @(posedge clk);
      #1;
      bus.redirect_valid = 1'b0;
      bus.exc_req        = 1'b0;
      cyc++;
   endtask

   task automatic wait_req();
      int n = 0;
      while (!bus.imem_req && n < 20) begin
         cycle();
         n++;
      end
      chk("wait_req", 32'(bus.imem_req), 32'd1);
   endtask

   task automatic wait_valid();
      int n = 0;
      while (!bus.inst_valid && n < 20) begin
         cycle();
         n++;
      end
      chk("wait_valid", 32'(bus.inst_valid), 32'd1);
   endtask

   initial begin
      int k, last, start_xfer;
      logic [31:0] a_hold, i_hold, pc_hold;

      bus.imem_gnt       = 1'b0;
      bus.imem_rvalid    = 1'b0;
      bus.imem_rdata     = 32'h0;
      bus.inst_ready     = 1'b1;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = 32'h0;
      bus.exc_req        = 1'b0;

      // Reset values
      repeat (3) cycle();
      chk("rst_req", 32'(bus.imem_req), 32'd0);
      chk("rst_addr", bus.imem_addr, RST_V);
      chk("rst_valid", 32'(bus.inst_valid), 32'd0);
      chk("rst_inst", bus.inst, 32'd0);
      chk("rst_inst_pc", bus.inst_pc, 32'd0);
      chk("rst_pc", bus.pc, RST_V);
      reset = 1'b0;

      // 1: back-to-back fetch, one instruction per 3 cycles
      k = 0;
      last = 0;
      for (int i = 0; i < 16; i++) begin
         if (bus.imem_req) begin
            chk("t1_addr", bus.imem_addr, 32'(4 * k));
            if (k > 0) chk("t1_spacing", 32'(cyc - last), 32'd3);
            last = cyc;
            k++;
         end
         cycle();
      end
      chk("t1_req_count", 32'(k), 32'd5);

      // 2: decode stalls for 5 cycles
      wait_valid();
      bus.inst_ready = 1'b0;
      i_hold  = bus.inst;
      pc_hold = bus.pc;
      for (int i = 0; i < 5; i++) begin
         cycle();
         chk("t2_valid", 32'(bus.inst_valid), 32'd1);
         chk("t2_inst", bus.inst, i_hold);
         chk("t2_no_req", 32'(bus.imem_req), 32'd0);
         chk("t2_pc", bus.pc, pc_hold);
      end
      bus.inst_ready = 1'b1;

      // 3: redirect while waiting for data
      gnt_mode = 1;
      rv_mode  = 2;
      wait_req();
      cycle();
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h0000_0103;
      cycle();
      chk("t3_wait_valid", 32'(bus.inst_valid), 32'd0);
      chk("t3_wait_req", 32'(bus.imem_req), 32'd0);
      rv_mode = 1;
      cycle();
      chk("t3_dropped", 32'(bus.inst_valid), 32'd0);
      chk("t3_req", 32'(bus.imem_req), 32'd1);
      chk("t3_addr", bus.imem_addr, 32'h0000_0100);

      // 4: exception and branch together in HOLD
      wait_valid();
      bus.inst_ready     = 1'b1;
      bus.exc_req        = 1'b1;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h0000_0200;
      cycle();
      chk("t4_valid", 32'(bus.inst_valid), 32'd0);
      chk("t4_req", 32'(bus.imem_req), 32'd1);
      chk("t4_addr", bus.imem_addr, EXC_V);

      // 5: grant withheld, redirect arrives before grant
      gnt_mode = 2;
      a_hold = bus.imem_addr;
      for (int i = 1; i <= 4; i++) begin
         if (i == 2) begin
            bus.redirect_valid = 1'b1;
            bus.redirect_pc    = 32'h0000_0300;
         end
         cycle();
         chk("t5_req", 32'(bus.imem_req), 32'd1);
         chk("t5_addr", bus.imem_addr, a_hold);
      end
      gnt_mode = 1;
      cycle();
      chk("t5_wait_valid", 32'(bus.inst_valid), 32'd0);
      cycle();
      chk("t5_killed", 32'(bus.inst_valid), 32'd0);
      chk("t5_req2", 32'(bus.imem_req), 32'd1);
      chk("t5_target", bus.imem_addr, 32'h0000_0300);

      // 6: pc wrap, then reset during WAIT
      wait_valid();
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'hFFFF_FFFF;
      cycle();
      chk("t6_top_addr", bus.imem_addr, 32'hFFFF_FFFC);
      cycle();
      cycle();
      chk("t6_top_valid", 32'(bus.inst_valid), 32'd1);
      chk("t6_top_pc", bus.inst_pc, 32'hFFFF_FFFC);
      cycle();
      chk("t6_wrap_req", 32'(bus.imem_req), 32'd1);
      chk("t6_wrap_addr", bus.imem_addr, 32'd0);
      rv_mode = 2;
      cycle();
      chk("t6_in_wait", 32'(bus.imem_req | bus.inst_valid), 32'd0);
      reset = 1'b1;
      #1;
      chk("t6_rst_req", 32'(bus.imem_req), 32'd0);
      chk("t6_rst_addr", bus.imem_addr, RST_V);
      chk("t6_rst_valid", 32'(bus.inst_valid), 32'd0);
      chk("t6_rst_inst", bus.inst, 32'd0);
      chk("t6_rst_inst_pc", bus.inst_pc, 32'd0);
      chk("t6_rst_pc", bus.pc, RST_V);
      cycle();
      cycle();
      reset = 1'b0;

      // Randomized traffic against the reference sequence
      gnt_mode   = 0;
      rv_mode    = 0;
      start_xfer = transfers;
      for (int i = 0; i < 3000; i++) begin
         bus.inst_ready     = ($urandom_range(0, 9) < 7);
         bus.redirect_valid = ($urandom_range(0, 99) < 7);
         bus.exc_req        = ($urandom_range(0, 99) < 2);
         bus.redirect_pc    = $urandom;
         cycle();
      end
      chk("rand_progress", 32'((transfers - start_xfer) > 100), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
